// File: rtl/interboard_tx_link_pkg.sv
// Shared definitions for the inter-board link; the receive side imports the same word type and parity helper.
package interboard_pkg;

    localparam int IB_DATA_W   = 11;
    localparam int IB_PARITY_W = 64;

    typedef logic [IB_DATA_W-1:0] ib_word_t;

    // Wide argument so any link width up to 64 bits can be zero-extended in without changing parity.
    function automatic logic ib_parity(input logic [IB_PARITY_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/interboard_tx_link_if.sv
// Signal bundle for the sender: local FIFO read port on one side, neighbouring-board handshake on the other.
interface interboard_tx_link_if
    import interboard_pkg::*;
#(
    parameter int DATA_W = IB_DATA_W
);
    logic [DATA_W-1:0] fifo_data;
    logic              empty;
    logic              rdreq;
    logic              read_input;
    logic              valid;
    logic [DATA_W-1:0] send_data;
    logic              send_parity;

    modport master (
        input  fifo_data, empty, read_input,
        output rdreq, valid, send_data, send_parity
    );

    modport slave (
        output fifo_data, empty, read_input,
        input  rdreq, valid, send_data, send_parity
    );
endinterface

// File: rtl/ib_skid_fifo.sv
// Register-array FIFO with synchronous reset; head and level come straight from flops.
module ib_skid_fifo
    import interboard_pkg::*;
#(
    parameter int W     = IB_DATA_W,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [W-1:0]                   push_data,
    input  logic                           pop,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = bump(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    assert property (@(posedge clk) disable iff (reset) !(push && !pop && level_q == LW'(DEPTH)));
    assert property (@(posedge clk) disable iff (reset) !(pop && level_q == '0));

endmodule

// File: rtl/interboard_tx_link.sv
// Inter-board sender: drains the local FIFO into a skid buffer sized so reads in flight always have a slot.
module interboard_tx_link
    import interboard_pkg::*;
#(
    parameter int DATA_W      = IB_DATA_W,
    parameter int FIFO_RD_LAT = 1,
    parameter int SKID_DEPTH  = 3,
    parameter bit PARITY_EN   = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                              input_clk,
    input  logic                              reset,
    interboard_tx_link_if.master              link,
    input  logic                              tx_enable,
    output logic [CNT_W-1:0]                  word_count,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   buf_level
);
    localparam int LW = $clog2(SKID_DEPTH + 1);
    localparam int OW = LW + 1;

    if (FIFO_RD_LAT < 1 || FIFO_RD_LAT > 3) begin : g_bad_lat
        $error("interboard_tx_link: FIFO_RD_LAT must be in 1..3");
    end
    if (SKID_DEPTH < FIFO_RD_LAT + 2) begin : g_bad_depth
        $error("interboard_tx_link: SKID_DEPTH must be at least FIFO_RD_LAT+2");
    end
    if (DATA_W > IB_PARITY_W) begin : g_bad_width
        $error("interboard_tx_link: DATA_W exceeds parity helper width");
    end

    logic [FIFO_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [CNT_W-1:0]       word_count_q, word_count_d;
    logic [OW-1:0]          occupancy;
    logic                   rdreq, push, pop, valid;
    logic [DATA_W-1:0]      head, send_word;
    logic [LW-1:0]          level;
    logic [IB_PARITY_W-1:0] par_word;

    ib_skid_fifo #(
        .W     (DATA_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (input_clk),
        .reset     (reset),
        .push      (push),
        .push_data (link.fifo_data),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    // Requests count against buffer space while still in flight, so a returning word is never refused.
    always_comb begin
        occupancy    = OW'(level) + OW'($countones(rd_pipe_q));
        rdreq        = ~reset & ~link.empty & tx_enable & (occupancy < OW'(SKID_DEPTH));
        push         = rd_pipe_q[FIFO_RD_LAT-1];
        valid        = (level != '0);
        pop          = valid & link.read_input;
        rd_pipe_d    = FIFO_RD_LAT'({rd_pipe_q, rdreq});
        word_count_d = word_count_q + CNT_W'(pop);
        send_word    = valid ? head : '0;
        par_word     = IB_PARITY_W'(send_word);
    end

    always_ff @(posedge input_clk) begin
        if (reset) begin
            rd_pipe_q    <= '0;
            word_count_q <= '0;
        end else begin
            rd_pipe_q    <= rd_pipe_d;
            word_count_q <= word_count_d;
        end
    end

    assign link.rdreq       = rdreq;
    assign link.valid       = valid;
    assign link.send_data   = send_word;
    assign link.send_parity = PARITY_EN ? ib_parity(par_word) : 1'b0;
    assign word_count       = word_count_q;
    assign buf_level        = level;

endmodule
